// File: rtl/shifter_arbiter.sv
// shifter_arbiter: round-robin sharing of one combinational barrel shifter between two requesters,
// with registered operands, a settle delay and a single valid/ready response channel.
module shifter_arbiter #(
    parameter int SETTLE_CYCLES = 1
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_req0_val,
    input  logic        i_req1_val,
    output logic        o_req0_rdy,
    output logic        o_req1_rdy,
    input  logic [31:0] i_req0_in,
    input  logic [31:0] i_req1_in,
    input  logic [4:0]  i_req0_shft,
    input  logic [4:0]  i_req1_shft,
    input  logic        i_req0_left,
    input  logic        i_req1_left,
    input  logic        i_req0_arith,
    input  logic        i_req1_arith,
    output logic [31:0] o_sh_in,
    output logic [4:0]  o_sh_shft,
    output logic        o_sh_left,
    output logic        o_sh_arith,
    input  logic [31:0] i_sh_out,
    output logic        o_rsp_val,
    input  logic        i_rsp_rdy,
    output logic [31:0] o_rsp_data,
    output logic        o_rsp_id,
    output logic        o_rsp_err,
    output logic        o_busy
);
    typedef enum logic [1:0] {IDLE, SETTLE, RESP} state_t;
    localparam logic [3:0] CNT_LAST = 4'(SETTLE_CYCLES - 1);
    state_t      r_state, w_next;
    logic        r_last, r_op_id, r_op_err, r_rsp_val, r_rsp_id, r_rsp_err;
    logic        r_sh_left, r_sh_arith;
    logic [31:0] r_sh_in, r_rsp_data;
    logic [4:0]  r_sh_shft;
    logic [3:0]  r_cnt;
    logic        w_gnt1, w_acc, w_done, w_left, w_arith;
    // On a tie the requester that did not win last time is granted.
    assign w_gnt1  = (i_req0_val && i_req1_val) ? !r_last : i_req1_val;
    assign w_acc   = (r_state == IDLE) && (i_req0_val || i_req1_val) && !i_rst;
    assign w_done  = (r_state == SETTLE) && (r_cnt == CNT_LAST);
    assign w_left  = w_gnt1 ? i_req1_left : i_req0_left;
    assign w_arith = w_gnt1 ? i_req1_arith : i_req0_arith;
    assign o_req0_rdy = w_acc && !w_gnt1;
    assign o_req1_rdy = w_acc && w_gnt1;
    assign o_busy     = (r_state != IDLE);
    assign o_sh_in    = r_sh_in;
    assign o_sh_shft  = r_sh_shft;
    assign o_sh_left  = r_sh_left;
    assign o_sh_arith = r_sh_arith;
    assign o_rsp_val  = r_rsp_val;
    assign o_rsp_data = r_rsp_data;
    assign o_rsp_id   = r_rsp_id;
    assign o_rsp_err  = r_rsp_err;
    always_comb begin
        w_next = r_state;
        w_next = w_acc ? SETTLE : w_done ? RESP : (r_state == RESP && i_rsp_rdy) ? IDLE : r_state;
    end
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) r_state <= IDLE;
        else       r_state <= w_next;
    end
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_last     <= 1'b1;
            r_op_id    <= 1'b0;
            r_op_err   <= 1'b0;
            r_sh_in    <= '0;
            r_sh_shft  <= '0;
            r_sh_left  <= 1'b0;
            r_sh_arith <= 1'b0;
            r_cnt      <= '0;
            r_rsp_val  <= 1'b0;
            r_rsp_data <= '0;
            r_rsp_id   <= 1'b0;
            r_rsp_err  <= 1'b0;
        end else begin
            if (w_acc) begin
                r_sh_in    <= w_gnt1 ? i_req1_in : i_req0_in;
                r_sh_shft  <= w_gnt1 ? i_req1_shft : i_req0_shft;
                r_sh_left  <= w_left;
                r_sh_arith <= w_arith && !w_left;
                r_op_err   <= w_arith && w_left;
                r_op_id    <= w_gnt1;
                r_last     <= w_gnt1;
                r_cnt      <= '0;
            end else if (r_state == SETTLE) begin
                r_cnt <= r_cnt + 4'd1;
            end
            if (w_done) begin
                r_rsp_val  <= 1'b1;
                r_rsp_data <= i_sh_out;
                r_rsp_id   <= r_op_id;
                r_rsp_err  <= r_op_err;
            end else if (r_state == RESP && i_rsp_rdy) begin
                r_rsp_val <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_shifter_arbiter.sv
// tb_shifter_arbiter: randomized and directed scoreboard bench for shifter_arbiter.
module tb_shifter_arbiter;
    localparam int SC = 1;
    typedef struct packed {logic [31:0] d; logic id; logic err;} rsp_t;
    logic        clk = 0, rst = 1;
    logic        v0 = 0, v1 = 0, l0 = 0, l1 = 0, a0 = 0, a1 = 0, rsp_rdy = 0;
    logic [31:0] in0 = 0, in1 = 0;
    logic [4:0]  s0 = 0, s1 = 0;
    logic        rdy0, rdy1, sh_left, sh_arith, rsp_val, rsp_id, rsp_err, busy;
    logic [31:0] sh_in, sh_out, rsp_data;
    logic [4:0]  sh_shft;
    logic        t_v0 = 0;
    logic [31:0] t_in = 0;
    logic [4:0]  t_shft = 0;
    logic        t_rdy0, t_rdy1, t_left, t_arith, t_val, t_id, t_err, t_busy;
    logic [31:0] t_sh_in, t_sh_out, t_data;
    logic [4:0]  t_sh_shft;
    int          n_cmp = 0, n_bad = 0, cyc = 0;
    rsp_t        q[$];
    int          acc_cyc[$];
    logic        acc_id[$];
    logic        m_busy = 0, m_last = 1, e_left = 0, e_arith = 0;
    int          m_wait = 0;
    logic [31:0] e_in = 0;
    logic [4:0]  e_shft = 0;

    always #5 clk = ~clk;
    assign sh_out   = sh_left ? sh_in << sh_shft : sh_arith ? 32'($signed(sh_in) >>> sh_shft) : sh_in >> sh_shft;
    assign t_sh_out = t_left ? t_sh_in << t_sh_shft : t_arith ? 32'($signed(t_sh_in) >>> t_sh_shft) : t_sh_in >> t_sh_shft;

    shifter_arbiter #(.SETTLE_CYCLES(SC)) dut (
        .i_clk(clk), .i_rst(rst), .i_req0_val(v0), .i_req1_val(v1), .o_req0_rdy(rdy0), .o_req1_rdy(rdy1),
        .i_req0_in(in0), .i_req1_in(in1), .i_req0_shft(s0), .i_req1_shft(s1), .i_req0_left(l0), .i_req1_left(l1),
        .i_req0_arith(a0), .i_req1_arith(a1), .o_sh_in(sh_in), .o_sh_shft(sh_shft), .o_sh_left(sh_left),
        .o_sh_arith(sh_arith), .i_sh_out(sh_out), .o_rsp_val(rsp_val), .i_rsp_rdy(rsp_rdy), .o_rsp_data(rsp_data),
        .o_rsp_id(rsp_id), .o_rsp_err(rsp_err), .o_busy(busy));

    shifter_arbiter #(.SETTLE_CYCLES(3)) dut3 (
        .i_clk(clk), .i_rst(rst), .i_req0_val(t_v0), .i_req1_val(1'b0), .o_req0_rdy(t_rdy0), .o_req1_rdy(t_rdy1),
        .i_req0_in(t_in), .i_req1_in(32'h0), .i_req0_shft(t_shft), .i_req1_shft(5'h0), .i_req0_left(1'b0),
        .i_req1_left(1'b0), .i_req0_arith(1'b0), .i_req1_arith(1'b0), .o_sh_in(t_sh_in), .o_sh_shft(t_sh_shft),
        .o_sh_left(t_left), .o_sh_arith(t_arith), .i_sh_out(t_sh_out), .o_rsp_val(t_val), .i_rsp_rdy(1'b1),
        .o_rsp_data(t_data), .o_rsp_id(t_id), .o_rsp_err(t_err), .o_busy(t_busy));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Shift result derived from the operation's meaning: right shifts pad with the sign bit when arithmetic.
    function automatic logic [31:0] ref_shift(input logic [31:0] x, input logic [4:0] n, input logic left, input logic arith);
        logic [31:0] fill;
        fill = (arith && x[31]) ? ~(32'hFFFF_FFFF >> n) : 32'h0;
        return left ? x << n : (x >> n) | fill;
    endfunction

    task automatic model_reset();
        q.delete();
        m_busy = 0; m_last = 1; m_wait = 0;
        e_in = 0; e_shft = 0; e_left = 0; e_arith = 0;
    endtask

    // One clock: check the DUT against the model just before the edge, then advance the model across it.
    task automatic step();
        logic g1, e0, e1, left, arith;
        rsp_t r;
        @(negedge clk);
        g1 = (v0 && v1) ? (m_last == 0) : v1;
        e0 = !m_busy && v0 && !g1;
        e1 = !m_busy && v1 && g1;
        chk("req0_rdy", 32'(rdy0), 32'(e0));
        chk("req1_rdy", 32'(rdy1), 32'(e1));
        chk("busy", 32'(busy), 32'(m_busy));
        chk("rsp_val", 32'(rsp_val), 32'(m_busy && m_wait == 0));
        chk("sh_in", sh_in, e_in);
        chk("sh_ctl", 32'({sh_shft, sh_left, sh_arith}), 32'({e_shft, e_left, e_arith}));
        if (e0 || e1) begin
            left  = e1 ? l1 : l0;
            arith = e1 ? a1 : a0;
            e_in = e1 ? in1 : in0;
            e_shft = e1 ? s1 : s0;
            e_left = left;
            e_arith = arith && !left;
            r.d = ref_shift(e_in, e_shft, left, e_arith);
            r.id = e1;
            r.err = arith && left;
            q.push_back(r);
            acc_cyc.push_back(cyc);
            acc_id.push_back(e1);
            m_busy = 1; m_wait = SC; m_last = e1;
        end else if (m_busy) begin
            if (m_wait > 0) m_wait--;
            else if (rsp_rdy) m_busy = 0;
        end
        @(posedge clk);
        cyc++;
        #1;
    endtask

    task automatic drain();
        int n = 0;
        v0 = 0; v1 = 0; rsp_rdy = 1;
        while (m_busy && n < 40) begin step(); n++; end
        if (m_busy) chk("drain_timeout", 32'(m_busy), 32'h0);
    endtask

    task automatic issue(input logic id, input logic [31:0] x, input logic [4:0] n, input logic left, input logic arith);
        drain();
        if (id) begin v1 = 1; in1 = x; s1 = n; l1 = left; a1 = arith; end
        else    begin v0 = 1; in0 = x; s0 = n; l0 = left; a0 = arith; end
        step();
        v0 = 0; v1 = 0;
    endtask

    initial forever begin : monitor
        rsp_t r;
        @(negedge clk);
        if (rsp_val && rsp_rdy && !rst) begin
            if (q.size() == 0) chk("rsp_unexpected", 32'(rsp_val), 32'h0);
            else begin
                r = q.pop_front();
                chk("rsp_data", rsp_data, r.d);
                chk("rsp_id", 32'(rsp_id), 32'(r.id));
                chk("rsp_err", 32'(rsp_err), 32'(r.err));
            end
        end
    end

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("rst_rdy", 32'({rdy0, rdy1}), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        rst = 0;
        step();
        // Both requesters held high: grants alternate 0,1,0,1 every three cycles.
        acc_cyc.delete(); acc_id.delete();
        rsp_rdy = 1; v0 = 1; v1 = 1;
        for (int i = 0; i < 12; i++) begin
            in0 = $urandom; in1 = $urandom; s0 = 5'($urandom); s1 = 5'($urandom);
            l0 = 1'($urandom); l1 = 1'($urandom); a0 = 1'($urandom); a1 = 1'($urandom);
            step();
        end
        chk("rr_count", 32'(acc_id.size()), 32'd4);
        for (int i = 0; i < 4 && i < acc_id.size(); i++) begin
            chk("rr_id", 32'(acc_id[i]), 32'(i % 2));
            if (i > 0) chk("rr_gap", 32'(acc_cyc[i] - acc_cyc[i-1]), 32'd3);
        end
        // Single left shift from requester 0.
        issue(0, 32'h8000_0001, 5'd4, 1, 0);
        step();
        chk("t1_val", 32'(rsp_val), 32'h1);
        chk("t1_data", rsp_data, 32'h0000_0010);
        chk("t1_id_err", 32'({rsp_id, rsp_err}), 32'h0);
        // LEFT+ARITH from requester 1: arithmetic is dropped and flagged.
        issue(1, 32'h8000_0000, 5'd1, 1, 1);
        chk("ill_sh_arith", 32'(sh_arith), 32'h0);
        step();
        chk("ill_data", rsp_data, 32'h0);
        chk("ill_id_err", 32'({rsp_id, rsp_err}), 32'h3);
        // Backpressure holds the response and blocks both requesters.
        rsp_rdy = 0;
        drain();
        rsp_rdy = 0;
        v0 = 1; in0 = 32'hF000_0000; s0 = 5'd8; l0 = 0; a0 = 1;
        step();
        v0 = 0;
        step();
        v0 = 1; v1 = 1;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("bp_data", rsp_data, 32'hFFF0_0000);
            chk("bp_hold", 32'({rsp_val, busy, rdy0, rdy1}), 32'hC);
        end
        rsp_rdy = 1; v0 = 0; v1 = 0;
        step();
        chk("bp_consumed", 32'(rsp_val), 32'h0);
        // Reset while in SETTLE discards the operation.
        issue(0, 32'h0000_00FF, 5'd3, 1, 0);
        v1 = 1; in1 = 32'h0000_0F00; s1 = 5'd4; l1 = 0; a1 = 0;
        rst = 1;
        #1;
        model_reset();
        chk("mr_sh_in", sh_in, 32'h0);
        chk("mr_sh_ctl", 32'({sh_shft, sh_left, sh_arith}), 32'h0);
        chk("mr_rsp", 32'({rsp_val, rsp_id, rsp_err, busy, rdy0, rdy1}), 32'h0);
        chk("mr_data", rsp_data, 32'h0);
        @(posedge clk);
        #1;
        chk("mr_rdy_in_rst", 32'({rdy0, rdy1}), 32'h0);
        rst = 0;
        step();
        chk("mr_accepted", 32'(acc_id[acc_id.size()-1]), 32'h1);
        v1 = 0;
        drain();
        // Random traffic with random backpressure.
        for (int i = 0; i < 400; i++) begin
            v0 = 1'($urandom); v1 = 1'($urandom); rsp_rdy = ($urandom_range(0, 3) != 0);
            in0 = $urandom; in1 = $urandom; s0 = 5'($urandom); s1 = 5'($urandom);
            l0 = 1'($urandom); l1 = 1'($urandom); a0 = 1'($urandom); a1 = 1'($urandom);
            step();
        end
        drain();
        step();
        chk("queue_empty", 32'(q.size()), 32'h0);
        // Three settle cycles on the second instance.
        t_v0 = 1; t_in = 32'h1234_5678; t_shft = 5'd16;
        @(negedge clk);
        chk("s3_rdy", 32'(t_rdy0), 32'h1);
        @(posedge clk);
        #1;
        t_v0 = 0;
        for (int j = 1; j <= 3; j++) begin
            @(posedge clk);
            #1;
            chk("s3_val", 32'(t_val), 32'(j == 3));
        end
        chk("s3_data", t_data, 32'h0000_1234);
        @(posedge clk);
        #1;
        chk("s3_done", 32'({t_val, t_busy}), 32'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
